selecionar_ativo: RTL
=====================

# selecionar_ativo

Downstream consumer of the active-node classifier: given the minimum criterion found over the NUM_NA active-node slots, this block scans the slots once, finds the lowest-index active node whose criterion equals that minimum, and returns its slot index, address and criterion to the search controller. It also generates the classifier's update pulse, so the controller sees one request/response handshake for "select best active node".

## Interface
- NUM_NA, 8: number of active-node slots; IDX_WIDTH = $clog2(NUM_NA).
- ADDR_WIDTH, 8: width of one node address.
- CRITERIO_WIDTH, 5: width of one criterion value.

- clk  input  1  clock; all state on rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- sa_iniciar_in  input  1  start request; sampled only in IDLE.
- ca_pronto_in  input  1  classifier done; sampled only in ESPERA.
- ca_criterio_geral_in  input  CRITERIO_WIDTH  classifier minimum; valid while ca_pronto_in=1.
- na_ativo_in  input  NUM_NA  per-slot active flags.
- na_criterio_in  input  NUM_NA*CRITERIO_WIDTH  packed criteria; slot i = bits [CRITERIO_WIDTH*i +: CRITERIO_WIDTH].
- na_endereco_in  input  NUM_NA*ADDR_WIDTH  packed addresses; slot i = bits [ADDR_WIDTH*i +: ADDR_WIDTH].
- sa_atualizar_o  output  1  one-cycle pulse to the classifier's update input.
- sa_ocupado_o  output  1  high whenever state != IDLE.
- sa_pronto_o  output  1  one-cycle result strobe.
- sa_valido_o  output  1  result found (qualifies outputs below).
- sa_indice_o  output  IDX_WIDTH  slot index of selected node.
- sa_endereco_o  output  ADDR_WIDTH  address of selected node.
- sa_criterio_o  output  CRITERIO_WIDTH  criterion of selected node.

## Operation
- States: IDLE, ATUALIZAR, ESPERA, VARRER, PRONTO.
- IDLE: sa_iniciar_in=1 -> ATUALIZAR. ca_pronto_in ignored.
- ATUALIZAR (1 cycle): sa_atualizar_o=1; -> ESPERA.
- ESPERA: on ca_pronto_in=1, latch ca_criterio_geral_in into alvo, idx<=0, -> VARRER. No timeout.
- VARRER: each cycle test slot idx: na_ativo_in[idx] && criterio[idx]==alvo.
  - Match: register sa_indice_o=idx, sa_endereco_o/sa_criterio_o from slot idx, sa_valido_o=1; -> PRONTO.
  - No match and idx==NUM_NA-1: sa_valido_o=0, index/address/criterion unchanged; -> PRONTO.
  - Otherwise idx<=idx+1.
- PRONTO (1 cycle): sa_pronto_o=1; -> IDLE.
- Ties: lowest matching index wins (first hit ends scan).
- No active slot: classifier returns all-ones, no slot matches -> sa_valido_o=0. An active slot with all-ones criterion does match -> valid.
- sa_iniciar_in while busy: ignored, not queued.
- Inputs na_* must be stable from ATUALIZAR through PRONTO; changes mid-scan are not tracked (single pass, no restart).
- idx compare uses full IDX_WIDTH; non-power-of-two NUM_NA never indexes past NUM_NA-1.

## Timing
- Reset (async, any state): state=IDLE, idx=0, alvo=all-ones, sa_atualizar_o=0, sa_ocupado_o=0, sa_pronto_o=0, sa_valido_o=0, sa_indice_o=0, sa_endereco_o=0, sa_criterio_o=all-ones. Reset mid-scan discards the operation; no sa_pronto_o.
- All outputs registered. sa_atualizar_o high in the cycle after sa_iniciar_in is sampled.
- ca_pronto_in sampled at edge P; slot k tested in cycle P+1+k; match at k -> sa_pronto_o high in cycle P+2+k. No match -> sa_pronto_o in cycle P+NUM_NA+1.
- sa_valido_o, sa_indice_o, sa_endereco_o, sa_criterio_o update together with sa_pronto_o and hold until the next result strobe.
- Minimum restart: sa_iniciar_in accepted in the cycle after PRONTO (back-to-back requests, one idle cycle).

## Test plan
- NUM_NA=8, CRITERIO_WIDTH=5, ADDR_WIDTH=8; ativo=8'b0010_0100, criteria slot2=9, slot5=3, addr5=0xA5; start -> one sa_atualizar_o pulse; after ca_pronto_in with 3, sa_pronto_o 7 cycles later, valido=1, indice=5, endereco=0xA5, criterio=3.
- Tie: slots 1 and 6 active, both criterion 4 -> indice=1, sa_pronto_o 3 cycles after ca_pronto_in.
- No active slots, classifier returns 31 -> valido=0, sa_pronto_o at P+9, previous index/address held.
- Slot 7 only active with criterion 31 -> valido=1, indice=7, criterio=31.
- sa_iniciar_in pulsed during ESPERA and VARRER -> no extra sa_atualizar_o, single sa_pronto_o; stray ca_pronto_in in IDLE -> no state change.
- rst_n asserted mid-VARRER -> all outputs at reset values immediately, state IDLE, no sa_pronto_o; next start completes normally.

Source files
------------

// File: rtl/selecionar_ativo_if.sv
// selecionar_ativo_if: request/response and classifier/slot signals of the active-node selector.
// master = controller/environment side, slave = selecionar_ativo.
interface selecionar_ativo_if #(
    parameter int NUM_NA         = 8,
    parameter int ADDR_WIDTH     = 8,
    parameter int CRITERIO_WIDTH = 5
);
    localparam int IDX_WIDTH = (NUM_NA > 1) ? $clog2(NUM_NA) : 1;

    logic                             sa_iniciar_in;
    logic                             ca_pronto_in;
    logic [CRITERIO_WIDTH-1:0]        ca_criterio_geral_in;
    logic [NUM_NA-1:0]                na_ativo_in;
    logic [NUM_NA*CRITERIO_WIDTH-1:0] na_criterio_in;
    logic [NUM_NA*ADDR_WIDTH-1:0]     na_endereco_in;

    logic                             sa_atualizar_o;
    logic                             sa_ocupado_o;
    logic                             sa_pronto_o;
    logic                             sa_valido_o;
    logic [IDX_WIDTH-1:0]             sa_indice_o;
    logic [ADDR_WIDTH-1:0]            sa_endereco_o;
    logic [CRITERIO_WIDTH-1:0]        sa_criterio_o;

    modport master (
        output sa_iniciar_in, ca_pronto_in, ca_criterio_geral_in,
               na_ativo_in, na_criterio_in, na_endereco_in,
        input  sa_atualizar_o, sa_ocupado_o, sa_pronto_o, sa_valido_o,
               sa_indice_o, sa_endereco_o, sa_criterio_o
    );

    modport slave (
        input  sa_iniciar_in, ca_pronto_in, ca_criterio_geral_in,
               na_ativo_in, na_criterio_in, na_endereco_in,
        output sa_atualizar_o, sa_ocupado_o, sa_pronto_o, sa_valido_o,
               sa_indice_o, sa_endereco_o, sa_criterio_o
    );
endinterface

// File: rtl/selecionar_ativo.sv
// selecionar_ativo: pulses the classifier update, waits for its minimum, then scans the
// slots once and returns the lowest-index active slot whose criterion equals that minimum.
module selecionar_ativo #(
    parameter int NUM_NA         = 8,
    parameter int ADDR_WIDTH     = 8,
    parameter int CRITERIO_WIDTH = 5
) (
    input logic               clk,
    input logic               rst_n,
    selecionar_ativo_if.slave bus
);
    localparam int IDX_WIDTH = (NUM_NA > 1) ? $clog2(NUM_NA) : 1;
    localparam logic [IDX_WIDTH-1:0] ULTIMO = IDX_WIDTH'(NUM_NA - 1);

    typedef enum logic [2:0] {
        IDLE,
        ATUALIZAR,
        ESPERA,
        VARRER,
        PRONTO
    } estado_t;

    estado_t                   estado, estado_prox;
    logic [IDX_WIDTH-1:0]      idx, idx_prox;
    logic [CRITERIO_WIDTH-1:0] alvo, alvo_prox;

    logic                      atualizar, atualizar_prox;
    logic                      ocupado, ocupado_prox;
    logic                      pronto, pronto_prox;
    logic                      valido, valido_prox;
    logic [IDX_WIDTH-1:0]      indice, indice_prox;
    logic [ADDR_WIDTH-1:0]     endereco, endereco_prox;
    logic [CRITERIO_WIDTH-1:0] criterio, criterio_prox;

    logic [CRITERIO_WIDTH-1:0] slot_criterio;
    logic [ADDR_WIDTH-1:0]     slot_endereco;
    logic                      acerto;

    // Fields of the slot currently under test and its match flag
    always_comb begin
        slot_criterio = bus.na_criterio_in[int'(idx)*CRITERIO_WIDTH +: CRITERIO_WIDTH];
        slot_endereco = bus.na_endereco_in[int'(idx)*ADDR_WIDTH +: ADDR_WIDTH];
        acerto        = bus.na_ativo_in[idx] && (slot_criterio == alvo);
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            estado <= IDLE;
        end else begin
            estado <= estado_prox;
        end
    end

    // Next state, scan datapath and next values of the registered outputs.
    // Outputs are computed from the next state so they appear in the same cycle as that state.
    always_comb begin
        estado_prox    = estado;
        idx_prox       = idx;
        alvo_prox      = alvo;
        atualizar_prox = 1'b0;
        pronto_prox    = 1'b0;
        valido_prox    = valido;
        indice_prox    = indice;
        endereco_prox  = endereco;
        criterio_prox  = criterio;

        case (estado)
            IDLE: begin
                if (bus.sa_iniciar_in) begin
                    estado_prox    = ATUALIZAR;
                    atualizar_prox = 1'b1;
                end
            end
            ATUALIZAR: begin
                estado_prox = ESPERA;
            end
            ESPERA: begin
                if (bus.ca_pronto_in) begin
                    alvo_prox   = bus.ca_criterio_geral_in;
                    idx_prox    = '0;
                    estado_prox = VARRER;
                end
            end
            VARRER: begin
                if (acerto) begin
                    valido_prox   = 1'b1;
                    indice_prox   = idx;
                    endereco_prox = slot_endereco;
                    criterio_prox = slot_criterio;
                    pronto_prox   = 1'b1;
                    estado_prox   = PRONTO;
                end else if (idx == ULTIMO) begin
                    valido_prox = 1'b0;
                    pronto_prox = 1'b1;
                    estado_prox = PRONTO;
                end else begin
                    idx_prox = idx + 1'b1;
                end
            end
            PRONTO: begin
                estado_prox = IDLE;
            end
            default: begin
                estado_prox = IDLE;
            end
        endcase

        ocupado_prox = (estado_prox != IDLE);
    end

    // Scan registers and registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx       <= '0;
            alvo      <= '1;
            atualizar <= 1'b0;
            ocupado   <= 1'b0;
            pronto    <= 1'b0;
            valido    <= 1'b0;
            indice    <= '0;
            endereco  <= '0;
            criterio  <= '1;
        end else begin
            idx       <= idx_prox;
            alvo      <= alvo_prox;
            atualizar <= atualizar_prox;
            ocupado   <= ocupado_prox;
            pronto    <= pronto_prox;
            valido    <= valido_prox;
            indice    <= indice_prox;
            endereco  <= endereco_prox;
            criterio  <= criterio_prox;
        end
    end

    assign bus.sa_atualizar_o = atualizar;
    assign bus.sa_ocupado_o   = ocupado;
    assign bus.sa_pronto_o    = pronto;
    assign bus.sa_valido_o    = valido;
    assign bus.sa_indice_o    = indice;
    assign bus.sa_endereco_o  = endereco;
    assign bus.sa_criterio_o  = criterio;
endmodule
